// File: rtl/systolic_seq_ctrl_if.sv
// Control bundle between a systolic-array sequencer and the logic around it.
// The master side requests passes; the slave side is the sequencer.
interface systolic_seq_ctrl_if #(
  parameter int ARRAY_DIM  = 4,
  parameter int KLEN_WIDTH = 8
);
  logic                         start;
  logic [KLEN_WIDTH-1:0]        k_len;
  logic                         hold;
  logic                         abort;
  logic                         pe_reset;
  logic                         pe_en;
  logic                         rd_en;
  logic [KLEN_WIDTH-1:0]        rd_addr;
  logic                         c_wr_en;
  logic [$clog2(ARRAY_DIM)-1:0] c_row;
  logic                         busy;
  logic                         done;

  modport master (
    output start, k_len, hold, abort,
    input  pe_reset, pe_en, rd_en, rd_addr, c_wr_en, c_row, busy, done
  );

  modport slave (
    input  start, k_len, hold, abort,
    output pe_reset, pe_en, rd_en, rd_addr, c_wr_en, c_row, busy, done
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for one matrix-multiply pass on a square systolic PE array:
// clear accumulators, stream k_len operand pairs, flush the skew, drain rows.
module systolic_seq_ctrl #(
  parameter int ARRAY_DIM  = 4,
  parameter int KLEN_WIDTH = 8
) (
  input logic                 clk,
  input logic                 reset,
  systolic_seq_ctrl_if.slave  bus
);
  localparam int ROW_W     = $clog2(ARRAY_DIM);
  localparam int FLUSH_LEN = 2 * ARRAY_DIM - 1;
  localparam int FLUSH_W   = $clog2(FLUSH_LEN + 1);
  localparam logic [FLUSH_W-1:0]    FLUSH_LAST = FLUSH_W'(FLUSH_LEN - 1);
  localparam logic [ROW_W-1:0]      ROW_LAST   = ROW_W'(ARRAY_DIM - 1);
  localparam logic [KLEN_WIDTH-1:0] ADDR_ONE   = KLEN_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FEED, S_FLUSH, S_DRAIN, S_DONE
  } state_t;

  state_t                  state;
  logic [KLEN_WIDTH-1:0]   k_len_q;
  logic [KLEN_WIDTH-1:0]   rd_addr_q;
  logic [FLUSH_W-1:0]      flush_cnt;
  logic [ROW_W-1:0]        c_row_q;
  logic                    pe_reset_q;
  logic                    pe_en_q;
  logic                    rd_en_q;
  logic                    c_wr_en_q;
  logic                    busy_q;
  logic                    done_q;
  logic [KLEN_WIDTH-1:0]   last_addr;

  // Comparing against k_len-1 keeps the address counter from ever wrapping.
  assign last_addr = k_len_q - ADDR_ONE;

  // Outputs are registered per state; each transition loads the strobes of
  // the state being entered so they are valid for that state's first cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      k_len_q    <= '0;
      rd_addr_q  <= '0;
      flush_cnt  <= '0;
      c_row_q    <= '0;
      pe_reset_q <= 1'b0;
      pe_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      c_wr_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else if (bus.abort && state != S_IDLE) begin
      state      <= S_IDLE;
      rd_addr_q  <= '0;
      flush_cnt  <= '0;
      c_row_q    <= '0;
      pe_reset_q <= 1'b0;
      pe_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      c_wr_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start && bus.k_len != '0) begin
            state      <= S_CLEAR;
            k_len_q    <= bus.k_len;
            pe_reset_q <= 1'b1;
            pe_en_q    <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        S_CLEAR: begin
          state      <= S_FEED;
          pe_reset_q <= 1'b0;
          rd_en_q    <= 1'b1;
          rd_addr_q  <= '0;
        end
        S_FEED: begin
          if (!bus.hold) begin
            if (rd_addr_q == last_addr) begin
              state     <= S_FLUSH;
              rd_en_q   <= 1'b0;
              rd_addr_q <= '0;
              flush_cnt <= '0;
            end else begin
              rd_addr_q <= rd_addr_q + ADDR_ONE;
            end
          end
        end
        S_FLUSH: begin
          if (!bus.hold) begin
            if (flush_cnt == FLUSH_LAST) begin
              state     <= S_DRAIN;
              pe_en_q   <= 1'b0;
              c_wr_en_q <= 1'b1;
              c_row_q   <= '0;
              flush_cnt <= '0;
            end else begin
              flush_cnt <= flush_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (!bus.hold) begin
            if (c_row_q == ROW_LAST) begin
              state     <= S_DONE;
              c_wr_en_q <= 1'b0;
              c_row_q   <= '0;
              done_q    <= 1'b1;
            end else begin
              c_row_q <= c_row_q + 1'b1;
            end
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // A stall must silence the array in the very cycle hold is raised; CLEAR
  // (the only state with pe_reset high) is exempt from stalling.
  assign bus.pe_reset = pe_reset_q;
  assign bus.pe_en    = pe_en_q & ~(bus.hold & ~pe_reset_q);
  assign bus.rd_en    = rd_en_q & ~bus.hold;
  assign bus.c_wr_en  = c_wr_en_q & ~bus.hold;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.c_row    = c_row_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule
